pulse_stretcher: RTL

- Converts single-cycle strobes into clean level pulses of a programmable width. It is the receive-side counterpart of the team's edge-to-strobe generators.
- Sits between strobe producers (edge detectors, event logic) and slow consumers (LEDs, external enables, handshake lines) that need a pulse longer than one cycle.
- Provides a queue mode (every strobe produces its own pulse) and a retrigger mode (strobes extend the current pulse).

---
 rtl/pulse_stretcher_pkg.sv | 21 ++
 rtl/pulse_stretcher_sat_updown_counter.sv | 45 ++++
 rtl/pulse_stretcher.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_pkg.sv
// ============================================================================
// Module  : pulse_stretcher_pkg
// Brief   : Shared state encoding and mode constants for the pulse stretcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic MODE_QUEUE  = 1'b0;
    localparam logic MODE_RETRIG = 1'b1;

endpackage : pulse_stretcher_pkg

`default_nettype wire

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// ============================================================================
// Module  : sat_updown_counter
// Brief   : Saturating up/down counter; simultaneous inc and dec cancel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_sat,
    output logic         o_zero
);

    logic [W-1:0] r_count;
    logic         w_up;
    logic         w_down;

    assign o_sat  = (r_count == {W{1'b1}});
    assign o_zero = (r_count == '0);

    // Counter pins at both ends rather than wrapping.
    assign w_up   = i_inc & ~i_dec & ~o_sat;
    assign w_down = i_dec & ~i_inc & ~o_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_up) begin
            r_count <= r_count + 1'b1;
        end else if (w_down) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_updown_counter

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// Module  : pulse_stretcher
// Brief   : Stretches single-cycle strobes into level pulses of programmable
//           width, with queue or retrigger handling of overlapping strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GAP    = 1,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  width,
    input  logic              mode,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int              GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    generate
        if (GAP < 1) begin : g_gap_invalid
            $error("pulse_stretcher: GAP must be at least 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [GAP_W-1:0] r_gcnt;
    logic [GAP_W-1:0] w_gcnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_overflow;
    logic             w_inc;
    logic             w_dec;
    logic             w_sat;
    logic             w_pend_zero;
    logic             w_drop;
    logic [CNT_W-1:0] w_hload;

    // A width of zero behaves like one: the counter holds remaining cycles minus one.
    assign w_hload = (width == '0) ? '0 : (width - 1'b1);

    sat_updown_counter #(
        .W (PEND_W)
    ) u_pend_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (pending),
        .o_sat   (w_sat),
        .o_zero  (w_pend_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_gcnt_nxt  = r_gcnt;
        w_level_nxt = r_level;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pulse_in) begin
                    w_state_nxt = ST_HIGH;
                    w_level_nxt = 1'b1;
                    w_hcnt_nxt  = w_hload;
                end
            end
            ST_HIGH: begin
                // A retrigger reload wins over the end-of-pulse exit.
                if (pulse_in && (mode == MODE_RETRIG)) begin
                    w_hcnt_nxt = w_hload;
                end else begin
                    w_inc = pulse_in;
                    if (r_hcnt == '0) begin
                        w_state_nxt = ST_GAP;
                        w_level_nxt = 1'b0;
                        w_gcnt_nxt  = GAP_LOAD;
                    end else begin
                        w_hcnt_nxt = r_hcnt - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gcnt != '0) begin
                    w_gcnt_nxt = r_gcnt - 1'b1;
                    w_inc      = pulse_in;
                end else if (!w_pend_zero || pulse_in) begin
                    w_state_nxt = ST_HIGH;
                    w_level_nxt = 1'b1;
                    w_hcnt_nxt  = w_hload;
                    // With an empty queue the strobe starts the pulse itself.
                    w_dec       = !w_pend_zero;
                    w_inc       = pulse_in && !w_pend_zero;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign w_drop = w_inc & ~w_dec & w_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hcnt     <= '0;
            r_gcnt     <= '0;
            r_level    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_gcnt     <= w_gcnt_nxt;
            r_level    <= w_level_nxt;
            r_overflow <= w_drop;
        end
    end

    assign level_out = r_level;
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;

endmodule : pulse_stretcher

`default_nettype wire
